// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle LEGv8 execute stage: ALU and branch
// condition codes, flag bit positions, FSM states and the deferred MUL controls.
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_XOR  = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_CBZ  = 2'b00,
        COND_LT   = 2'b01,
        COND_CBNZ = 2'b10,
        COND_EQ   = 2'b11
    } cond_sel_e;

    // Position of each flag inside the {N,Z,V,C} register
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // EX/MEM side-band captured when a MUL is accepted, replayed when it retires
    typedef struct packed {
        logic [4:0] rd;
        logic       f_enable;
        logic       pc_select;
    } mul_ctl_t;

endpackage

// File: rtl/ex_stage_mc_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle;
// product is the low WIDTH bits and is valid in the cycle done is high.
module mul_iter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned MUL_BPC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int unsigned STEPS = WIDTH / MUL_BPC;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] partial;

    always_comb begin
        partial  = '0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        for (int j = 0; j < int'(MUL_BPC); j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
        if (start && !busy) begin
            cnt_d    = CNT_W'(STEPS);
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (busy) begin
            cnt_d    = cnt_q - CNT_W'(1);
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_BPC;
            mplier_d = mplier_q >> MUL_BPC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = (cnt_q == CNT_W'(1));
    // Includes the final step so the caller can retire on the same edge
    assign product = acc_d;

endmodule

// File: rtl/ex_stage_mc.sv
// Registered LEGv8 execute stage: ALU, bidirectional shifter, branch resolve and
// an iterative multiplier behind a valid/ready stall, ending in the EX/MEM register.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned MUL_BPC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Da,
    input  logic [WIDTH-1:0] Db,
    input  logic [31:0]      instr,
    input  logic             alu_src,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             br_taken,
    input  logic             uncond_br,
    input  logic             big_imm,
    input  logic             shift_en,
    input  logic             shift_dir,
    input  logic             set_flag,
    input  logic             mul_en,
    input  logic [2:0]       alu_op,
    input  logic [1:0]       cond_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd,
    output logic             f_enable,
    output logic             pc_select,
    output logic [3:0]       flags
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             f_enable_q, f_enable_d;
    logic             pc_select_q, pc_select_d;
    logic [3:0]       flags_q, flags_d;
    mul_ctl_t         mul_ctl_q, mul_ctl_d;

    logic             accept;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] imm9, imm12, alu_b, b_op, alu_res, shift_res;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]   sum;
    logic             is_sub, is_arith, alu_v, alu_c;
    logic [3:0]       alu_flags;
    logic             cond, branch;
    logic             unused_instr;

    assign accept    = in_valid & in_ready;
    assign mul_start = accept & mul_en;
    assign in_ready  = (state_q == IDLE);

    // Operand selection and shifter
    assign imm9      = {{(WIDTH-9){instr[20]}}, instr[20:12]};
    assign imm12     = {{(WIDTH-12){1'b0}}, instr[21:10]};
    assign alu_b     = alu_src ? (big_imm ? imm12 : imm9) : Db;
    assign shamt     = instr[10 +: SHAMT_W];
    assign shift_res = shift_dir ? (Da >> shamt) : (Da << shamt);

    assign unused_instr = ^{instr[31:22], instr[15:10], instr[9:5]};

    always_comb begin
        is_sub   = (alu_op == ALU_SUB);
        is_arith = 1'b0;
        b_op     = is_sub ? ~alu_b : alu_b;
        sum      = {1'b0, Da} + {1'b0, b_op} + (WIDTH+1)'(is_sub);
        alu_res  = alu_b;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                is_arith = 1'b1;
            end
            ALU_AND: alu_res = Da & alu_b;
            ALU_OR:  alu_res = Da | alu_b;
            ALU_XOR: alu_res = Da ^ alu_b;
            default: alu_res = alu_b;
        endcase
        alu_v     = is_arith & (Da[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != Da[WIDTH-1]);
        alu_c     = is_arith & sum[WIDTH];
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
    end

    // Zero tests use the live operand, flag tests use the stored register
    always_comb begin
        cond = 1'b0;
        case (cond_sel)
            COND_CBZ:  cond = (Db == '0);
            COND_LT:   cond = flags_q[FLAG_N] ^ flags_q[FLAG_V];
            COND_CBNZ: cond = (Db != '0);
            COND_EQ:   cond = flags_q[FLAG_Z];
            default:   cond = 1'b0;
        endcase
        branch = uncond_br ? br_taken : (br_taken & cond);
    end

    mul_iter #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (Da),
        .b       (Db),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        pc_select_d = 1'b0;
        result_d    = result_q;
        rd_d        = rd_q;
        f_enable_d  = f_enable_q;
        flags_d     = flags_q;
        mul_ctl_d   = mul_ctl_q;
        case (state_q)
            IDLE: begin
                if (accept && mul_en) begin
                    state_d             = BUSY;
                    mul_ctl_d.rd        = instr[4:0];
                    mul_ctl_d.f_enable  = ~mem_to_reg & reg_write;
                    mul_ctl_d.pc_select = branch;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = shift_en ? shift_res : alu_res;
                    rd_d        = instr[4:0];
                    f_enable_d  = ~mem_to_reg & reg_write;
                    pc_select_d = branch;
                    if (set_flag && !shift_en) begin
                        flags_d = alu_flags;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_product;
                    rd_d        = mul_ctl_q.rd;
                    f_enable_d  = mul_ctl_q.f_enable;
                    pc_select_d = mul_ctl_q.pc_select;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            f_enable_q  <= 1'b0;
            pc_select_q <= 1'b0;
            flags_q     <= '0;
            mul_ctl_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            f_enable_q  <= f_enable_d;
            pc_select_q <= pc_select_d;
            flags_q     <= flags_d;
            mul_ctl_q   <= mul_ctl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd        = rd_q;
    assign f_enable  = f_enable_q;
    assign pc_select = pc_select_q;
    assign flags     = flags_q;

endmodule
